icache_assoc: RTL

Parametrised set-associative instruction cache sitting between the fetch stage and the memory controller. It generalises the single-word direct-mapped icache to configurable sets, ways and words-per-block. Misses are refilled by a block-fill state machine with round-robin replacement, and the cache supports a global flush and a miss counter.

---
 rtl/icache_assoc_if.sv | 23 ++
 rtl/icache_assoc.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/icache_assoc_if.sv
// rtl/icache_assoc_if.sv - fetch-side and memory-side signal bundle for icache_assoc
interface icache_assoc_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic [15:0] miss_count;

    modport slave (
        input  imemREN, imemaddr, flush, iload, iwait,
        output ihit, imemload, iREN, iaddr, miss_count
    );

    modport master (
        output imemREN, imemaddr, flush, iload, iwait,
        input  ihit, imemload, iREN, iaddr, miss_count
    );
endinterface

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative instruction cache with block refill
module icache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input logic           CLK,
    input logic           nRST,
    icache_assoc_if.slave bus
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int WOFF_W = $clog2(WORDS);
    localparam int TAG_W  = 30 - IDX_W - WOFF_W;
    localparam int FA_W   = TAG_W + IDX_W;
    localparam int WC_W   = (WOFF_W > 0) ? WOFF_W : 1;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic              valid_q [SETS][WAYS];
    logic              valid_d [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
    logic [31:0]       data_q  [SETS][WAYS][WORDS];
    logic [31:0]       data_d  [SETS][WAYS][WORDS];
    logic [PTR_W-1:0]  ptr_q   [SETS];
    logic [PTR_W-1:0]  ptr_d   [SETS];
    logic [31:0]       buf_q   [WORDS];
    logic [31:0]       buf_d   [WORDS];
    logic [FA_W-1:0]   fill_addr_q, fill_addr_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [15:0]       miss_count_q, miss_count_d;

    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  lk_idx;
    logic [WC_W-1:0]   lk_woff;
    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic              hit;
    logic [31:0]       hit_word;
    logic [PTR_W-1:0]  vict;
    logic              all_valid;
    logic              ihit_c;
    logic [31:0]       imemload_c;
    logic              iren_c;
    logic [31:0]       iaddr_c;
    logic              unused_byte_off;

    assign lk_tag          = bus.imemaddr[31 -: TAG_W];
    assign lk_idx          = bus.imemaddr[2+WOFF_W +: IDX_W];
    assign lk_woff         = (WOFF_W > 0) ? bus.imemaddr[2 +: WC_W] : '0;
    assign f_idx           = fill_addr_q[IDX_W-1:0];
    assign f_tag           = fill_addr_q[FA_W-1 -: TAG_W];
    assign unused_byte_off = ^bus.imemaddr[1:0];

    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                hit      = 1'b1;
                hit_word = data_q[lk_idx][w][lk_woff];
            end
        end
    end

    // Lowest invalid way wins; the round-robin pointer only decides a full set.
    always_comb begin
        all_valid = 1'b1;
        vict      = ptr_q[f_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[f_idx][w]) begin
                vict      = PTR_W'(w);
                all_valid = 1'b0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        ptr_d        = ptr_q;
        buf_d        = buf_q;
        fill_addr_d  = fill_addr_q;
        wcnt_d       = wcnt_q;
        miss_count_d = miss_count_q;
        ihit_c       = 1'b0;
        imemload_c   = '0;
        iren_c       = 1'b0;
        iaddr_c      = '0;

        case (state_q)
            IDLE: begin
                if (bus.imemREN) begin
                    if (hit) begin
                        ihit_c     = 1'b1;
                        imemload_c = hit_word;
                    end else begin
                        fill_addr_d  = {lk_tag, lk_idx};
                        wcnt_d       = '0;
                        miss_count_d = miss_count_q + 16'd1;
                        state_d      = FILL;
                    end
                end
            end
            FILL: begin
                iren_c  = 1'b1;
                iaddr_c = {fill_addr_q, {(WOFF_W + 2){1'b0}}} | (32'(wcnt_q) << 2);
                if (bus.flush) begin
                    wcnt_d  = '0;
                    state_d = IDLE;
                end else if (!bus.iwait) begin
                    buf_d[wcnt_q] = bus.iload;
                    wcnt_d        = wcnt_q + 1'b1;
                    if (wcnt_q == WC_W'(WORDS - 1)) begin
                        valid_d[f_idx][vict] = 1'b1;
                        tag_d[f_idx][vict]   = f_tag;
                        for (int wd = 0; wd < WORDS; wd++) begin
                            data_d[f_idx][vict][wd] = (wd == WORDS - 1) ? bus.iload : buf_q[wd];
                        end
                        if (all_valid && WAYS > 1) begin
                            ptr_d[f_idx] = (ptr_q[f_idx] == PTR_W'(WAYS - 1)) ? '0
                                                                              : ptr_q[f_idx] + 1'b1;
                        end
                        wcnt_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_d[s][w] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            fill_addr_q  <= '0;
            wcnt_q       <= '0;
            miss_count_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else begin
            state_q      <= state_d;
            fill_addr_q  <= fill_addr_d;
            wcnt_q       <= wcnt_d;
            miss_count_q <= miss_count_d;
            ptr_q        <= ptr_d;
            valid_q      <= valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
        buf_q  <= buf_d;
    end

    assign bus.ihit       = ihit_c;
    assign bus.imemload   = imemload_c;
    assign bus.iREN       = iren_c;
    assign bus.iaddr      = iaddr_c;
    assign bus.miss_count = miss_count_q;
endmodule
